// File: rtl/pipe_pkg.sv
// Shared state encoding, control-bit indices and default widths for the pipeline stage register.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

   localparam int CTRL_WREG  = 0;
   localparam int CTRL_M2REG = 1;
   localparam int CTRL_WMEM  = 2;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_RN_W   = 5;
   localparam int DEF_CTRL_W = 3;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enabled-load payload register with asynchronous active-high clear.
module pipe_payload_reg #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // payload storage, loaded only when the owning stage commits a transfer
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush; optional skid entry enabled by PIPE_STAGE_SKID_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int RN_W   = DEF_RN_W,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_b,
   input  logic [RN_W-1:0]   in_rn,
   input  logic              in_zero,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_b,
   output logic [RN_W-1:0]   out_rn,
   output logic              out_zero,
   output logic [1:0]        occupancy
);

   localparam int PW = CTRL_W + 2 * DATA_W + RN_W + 1;

   pipe_state_e       r_state;
   pipe_state_e       w_state_nxt;
   logic              w_accept;
   logic              w_drain;
   logic              w_load_main;
   logic              w_load_skid;
   logic [PW-1:0]     w_in_pl;
   logic [PW-1:0]     w_main_d;
   logic [PW-1:0]     w_main_q;
   logic [CTRL_W-1:0] w_main_ctrl;

   assign w_in_pl   = {in_ctrl, in_alu, in_b, in_rn, in_zero};
   assign out_valid = (r_state != ST_EMPTY);
   assign w_accept  = in_valid & in_ready & ~flush;
   assign w_drain   = out_valid & out_ready;
   assign occupancy = r_state;

`ifdef PIPE_STAGE_SKID_EN
   logic          r_in_ready;
   logic [PW-1:0] w_skid_q;

   // registered ready: deasserted exactly while the stage will hold two entries
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_in_ready <= 1'b1;
      end else begin
         r_in_ready <= (w_state_nxt != ST_TWO);
      end
   end

   assign in_ready = r_in_ready;

   pipe_payload_reg #(.W(PW)) u_skid (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_load (w_load_skid),
      .i_d    (w_in_pl),
      .o_q    (w_skid_q)
   );
`else
   assign in_ready = ~out_valid | out_ready;
`endif

   // occupancy state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state and entry-load decode; flush overrides accept and drain
   always_comb begin
      w_state_nxt = r_state;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_main_d    = w_in_pl;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_load_main = 1'b1;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  w_load_main = 1'b1;
               end else if (w_accept) begin
`ifdef PIPE_STAGE_SKID_EN
                  w_state_nxt = ST_TWO;
                  w_load_skid = 1'b1;
`else
                  w_load_main = 1'b1;
`endif
               end else if (w_drain) begin
                  w_state_nxt = ST_EMPTY;
               end else begin
                  w_state_nxt = ST_ONE;
               end
            end
            ST_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
               if (w_drain) begin
                  w_state_nxt = ST_ONE;
                  w_load_main = 1'b1;
                  w_main_d    = w_skid_q;
               end else begin
                  w_state_nxt = ST_TWO;
               end
`else
               w_state_nxt = ST_EMPTY;
`endif
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   pipe_payload_reg #(.W(PW)) u_main (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_load (w_load_main),
      .i_d    (w_main_d),
      .o_q    (w_main_q)
   );

   assign {w_main_ctrl, out_alu, out_b, out_rn, out_zero} = w_main_q;
   // a bubble must never carry write enables downstream
   assign out_ctrl = out_valid ? w_main_ctrl : {CTRL_W{1'b0}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; covers both PIPE_STAGE_SKID_EN builds.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_ctrl;
   logic [31:0] in_alu;
   logic [31:0] in_b;
   logic [4:0]  in_rn;
   logic        in_zero;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_ctrl;
   logic [31:0] out_alu;
   logic [31:0] out_b;
   logic [4:0]  out_rn;
   logic        out_zero;
   logic [1:0]  occupancy;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.DATA_W(32), .RN_W(5), .CTRL_W(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_alu    (in_alu),
      .in_b      (in_b),
      .in_rn     (in_rn),
      .in_zero   (in_zero),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_alu   (out_alu),
      .out_b     (out_b),
      .out_rn    (out_rn),
      .out_zero  (out_zero),
      .occupancy (occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [2:0] ctrl, input logic [4:0] rn);
      in_valid = v;
      in_alu   = alu;
      in_ctrl  = ctrl;
      in_rn    = rn;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_ctrl = 3'b000; in_alu = 32'h0; in_b = 32'h0;
      in_rn = 5'd0; in_zero = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #3;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_occ",       {30'd0, occupancy}, 32'd0);
      check("rst_out_alu",   out_alu,            32'd0);
      check("rst_out_ctrl",  {29'd0, out_ctrl},  32'd0);
      step();
      step();
      reset = 1'b0;

      // single transfer, 1-cycle latency
      drive(1'b1, 32'h0000_00AA, 3'b001, 5'd5);
      in_b = 32'h0000_1234; in_zero = 1'b1; out_ready = 1'b1;
      step();
      drive(1'b0, 32'h0, 3'b000, 5'd0); in_zero = 1'b0;
      check("t1_out_valid", {31'd0, out_valid}, 32'd1);
      check("t1_out_alu",   out_alu,            32'h0000_00AA);
      check("t1_out_rn",    {27'd0, out_rn},    32'd5);
      check("t1_out_ctrl",  {29'd0, out_ctrl},  32'd1);
      check("t1_out_b",     out_b,              32'h0000_1234);
      check("t1_out_zero",  {31'd0, out_zero},  32'd1);
      check("t1_occ",       {30'd0, occupancy}, 32'd1);
      step();
      check("t1_drained_valid", {31'd0, out_valid}, 32'd0);
      check("t1_bubble_ctrl",   {29'd0, out_ctrl},  32'd0);
      check("t1_hold_alu",      out_alu,            32'h0000_00AA);
      check("t1_drained_occ",   {30'd0, occupancy}, 32'd0);

      // streaming: accept and drain every cycle
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 3'b001, 5'd1);
         step();
         check("stream_alu",   out_alu,            32'h100 + 32'(i));
         check("stream_occ",   {30'd0, occupancy}, 32'd1);
         check("stream_ready", {31'd0, in_ready},  32'd1);
      end
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      step();
      check("stream_end_occ", {30'd0, occupancy}, 32'd0);

      // flush at occupancy 1 with a competing payload
      out_ready = 1'b0;
      drive(1'b1, 32'h55, 3'b111, 5'd2);
      step();
      check("fl1_occ", {30'd0, occupancy}, 32'd1);
      flush = 1'b1;
      drive(1'b1, 32'h66, 3'b111, 5'd3);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      check("fl1_valid", {31'd0, out_valid}, 32'd0);
      check("fl1_ctrl",  {29'd0, out_ctrl},  32'd0);
      check("fl1_occ",   {30'd0, occupancy}, 32'd0);
      check("fl1_ready", {31'd0, in_ready},  32'd1);
      check("fl1_alu",   out_alu,            32'h55);
      step();
      check("fl1_after_occ", {30'd0, occupancy}, 32'd0);

`ifdef PIPE_STAGE_SKID_EN
      // fill main and skid while downstream stalls
      drive(1'b1, 32'h11, 3'b001, 5'd1);
      step();
      check("sk_occ1",   {30'd0, occupancy}, 32'd1);
      check("sk_ready1", {31'd0, in_ready},  32'd1);
      drive(1'b1, 32'h22, 3'b010, 5'd2);
      step();
      check("sk_occ2",   {30'd0, occupancy}, 32'd2);
      check("sk_ready2", {31'd0, in_ready},  32'd0);
      check("sk_alu_a",  out_alu,            32'h11);
      drive(1'b1, 32'h99, 3'b100, 5'd9);
      step();
      check("sk_hold_occ", {30'd0, occupancy}, 32'd2);
      check("sk_hold_alu", out_alu,            32'h11);
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      out_ready = 1'b1;
      step();
      check("sk_alu_b",   out_alu,            32'h22);
      check("sk_ctrl_b",  {29'd0, out_ctrl},  32'd2);
      check("sk_occ_b",   {30'd0, occupancy}, 32'd1);
      check("sk_ready_b", {31'd0, in_ready},  32'd1);
      step();
      check("sk_empty_occ",   {30'd0, occupancy}, 32'd0);
      check("sk_empty_valid", {31'd0, out_valid}, 32'd0);

      // flush at occupancy 2
      out_ready = 1'b0;
      drive(1'b1, 32'h44, 3'b001, 5'd4);
      step();
      drive(1'b1, 32'h45, 3'b001, 5'd4);
      step();
      check("fl2_pre_occ", {30'd0, occupancy}, 32'd2);
      flush = 1'b1;
      drive(1'b1, 32'h77, 3'b111, 5'd7);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      out_ready = 1'b1;
      check("fl2_valid", {31'd0, out_valid}, 32'd0);
      check("fl2_ctrl",  {29'd0, out_ctrl},  32'd0);
      check("fl2_occ",   {30'd0, occupancy}, 32'd0);
      check("fl2_ready", {31'd0, in_ready},  32'd1);
      step();
      check("fl2_no_ghost_valid", {31'd0, out_valid}, 32'd0);
      check("fl2_no_ghost_alu",   out_alu,            32'h44);

      // fill to two for the asynchronous reset test
      out_ready = 1'b0;
      drive(1'b1, 32'h81, 3'b001, 5'd1);
      step();
      drive(1'b1, 32'h82, 3'b001, 5'd1);
      step();
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      check("ar_pre_occ", {30'd0, occupancy}, 32'd2);
`else
      // single-entry build: ready follows out_ready combinationally
      drive(1'b1, 32'h11, 3'b001, 5'd1);
      step();
      check("ns_occ1",  {30'd0, occupancy}, 32'd1);
      check("ns_ready", {31'd0, in_ready},  32'd0);
      drive(1'b1, 32'h22, 3'b010, 5'd2);
      step();
      check("ns_occ_cap", {30'd0, occupancy}, 32'd1);
      check("ns_hold",    out_alu,            32'h11);
      out_ready = 1'b1;
      #1;
      check("ns_ready_comb", {31'd0, in_ready}, 32'd1);
      step();
      check("ns_alu_b", out_alu,            32'h22);
      check("ns_occ_b", {30'd0, occupancy}, 32'd1);
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      step();
      check("ns_empty", {30'd0, occupancy}, 32'd0);

      out_ready = 1'b0;
      drive(1'b1, 32'h81, 3'b001, 5'd1);
      step();
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      check("ar_pre_occ", {30'd0, occupancy}, 32'd1);
`endif

      // asynchronous reset between clock edges
      #2;
      reset = 1'b1;
      #1;
      check("ar_valid", {31'd0, out_valid}, 32'd0);
      check("ar_occ",   {30'd0, occupancy}, 32'd0);
      check("ar_ready", {31'd0, in_ready},  32'd1);
      check("ar_alu",   out_alu,            32'd0);
      step();
      reset = 1'b0;
      drive(1'b1, 32'h90, 3'b001, 5'd6);
      step();
      drive(1'b0, 32'h0, 3'b000, 5'd0);
      check("post_rst_alu", out_alu,            32'h90);
      check("post_rst_occ", {30'd0, occupancy}, 32'd1);
      out_ready = 1'b1;
      step();
      check("post_rst_drain", {30'd0, occupancy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
